// File: rtl/qr_row_feeder.sv
// Ping-pong row buffer feeding the 4-column CORDIC QR array: stores host rows,
// then replays each full matrix one row per ROW_CYCLES clocks with a drain gap.

module qr_row_feeder_lane #(
    parameter int WIDTH = 13,
    parameter int ROWS  = 4,
    parameter int RW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    wr_bank,
    input  logic [RW-1:0]           wr_row,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic                    rd_bank,
    input  logic [RW-1:0]           rd_row,
    output logic [WIDTH-1:0]        data_out
);
    logic [WIDTH-1:0] mem [2][ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank][wr_row] <= wr_data;
    end

    // Column output register: zero whenever no row is being streamed.
    always_ff @(posedge clk) begin
        if (reset)      data_out <= '0;
        else if (rd_en) data_out <= mem[rd_bank][rd_row];
        else            data_out <= '0;
    end
endmodule

module qr_row_feeder #(
    parameter int WIDTH      = 13,
    parameter int ROWS       = 4,
    parameter int ROW_CYCLES = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WIDTH-1:0]  in_rowA,
    input  logic signed [WIDTH-1:0]  in_rowB,
    input  logic signed [WIDTH-1:0]  in_rowC,
    input  logic signed [WIDTH-1:0]  in_rowD,
    output logic signed [WIDTH-1:0]  data_outA,
    output logic signed [WIDTH-1:0]  data_outB,
    output logic signed [WIDTH-1:0]  data_outC,
    output logic signed [WIDTH-1:0]  data_outD,
    output logic                     last_end,
    output logic                     mat_start,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     busy
);
    localparam int NUM_LANES = 4;
    localparam int RW = $clog2(ROWS);
    localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t          state;
    logic [1:0]      full;
    logic [1:0]      set_mask, clr_mask;
    logic            wr_bank, rd_bank;
    logic [RW-1:0]   wr_row, row_cnt;
    logic [CW-1:0]   cyc_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            accept, last_wr, row_wrap, last_row, stream_done;

    logic [NUM_LANES-1:0][WIDTH-1:0] col_in, col_out;

    assign in_ready    = !full[wr_bank];
    assign accept      = in_valid && in_ready;
    assign last_wr     = (wr_row == RW'(ROWS - 1));
    assign row_wrap    = (cyc_cnt == CW'(ROW_CYCLES - 1));
    assign last_row    = (row_cnt == RW'(ROWS - 1));
    assign stream_done = (state == STREAM) && row_wrap && last_row;

    // Set and clear never hit the same bank: a writable wr_bank is empty.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (accept && last_wr) set_mask[wr_bank] = 1'b1;
        if (stream_done)       clr_mask[rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= '0;
            wr_bank <= 1'b0;
            wr_row  <= '0;
        end else begin
            full <= (full & ~clr_mask) | set_mask;
            if (accept) begin
                if (last_wr) begin
                    wr_row  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            row_cnt   <= '0;
            cyc_cnt   <= '0;
            gap_cnt   <= '0;
            last_end  <= 1'b0;
            mat_start <= 1'b0;
            row_idx   <= '0;
            busy      <= 1'b0;
        end else begin
            last_end  <= 1'b0;
            mat_start <= 1'b0;
            row_idx   <= '0;
            busy      <= (state != IDLE);
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state   <= STREAM;
                        row_cnt <= '0;
                        cyc_cnt <= '0;
                    end
                end
                STREAM: begin
                    row_idx   <= row_cnt;
                    last_end  <= last_row;
                    mat_start <= (row_cnt == '0) && (cyc_cnt == '0);
                    if (row_wrap) begin
                        cyc_cnt <= '0;
                        if (last_row) begin
                            row_cnt <= '0;
                            rd_bank <= ~rd_bank;
                            // Without a gap, chain straight into a queued matrix.
                            if (GAP_CYCLES == 0) begin
                                state <= full[~rd_bank] ? STREAM : IDLE;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= '0;
                            end
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
                    else                                gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign col_in = {in_rowD, in_rowC, in_rowB, in_rowA};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        qr_row_feeder_lane #(
            .WIDTH (WIDTH),
            .ROWS  (ROWS),
            .RW    (RW)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (accept),
            .wr_bank  (wr_bank),
            .wr_row   (wr_row),
            .wr_data  (col_in[i]),
            .rd_en    (state == STREAM),
            .rd_bank  (rd_bank),
            .rd_row   (row_cnt),
            .data_out (col_out[i])
        );
    end

    assign data_outA = col_out[0];
    assign data_outB = col_out[1];
    assign data_outC = col_out[2];
    assign data_outD = col_out[3];
endmodule

// File: tb/tb_qr_row_feeder.sv
// Directed bench for qr_row_feeder: row scoreboard plus timing checks on a
// default instance and a no-gap, single-cycle-row instance.

module tb_qr_row_feeder;
    localparam int W    = 13;
    localparam int ROWS = 4;
    localparam int RC   = 4;

    typedef struct { logic signed [W-1:0] a, b, c, d; } row_t;
    typedef struct { row_t d; logic le, ms, bz; } snap_t;

    logic clk = 0, reset = 1;
    logic in_valid = 0, in_valid2 = 0;
    logic signed [W-1:0] in_rowA = 0, in_rowB = 0, in_rowC = 0, in_rowD = 0;
    logic signed [W-1:0] in2A = 0, in2B = 0, in2C = 0, in2D = 0;
    logic in_ready, last_end, mat_start, busy;
    logic signed [W-1:0] data_outA, data_outB, data_outC, data_outD;
    logic [1:0] row_idx;
    logic in_ready2, last_end2, mat_start2, busy2;
    logic signed [W-1:0] d2A, d2B, d2C, d2D;
    logic [1:0] row_idx2;

    int n_assert = 0, n_fail = 0;
    int k = -1;
    row_t cur;
    row_t sb[$], sb2[$];
    snap_t log2[$];
    logic log2_en = 0;

    always #5 clk = ~clk;

    qr_row_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rowA(in_rowA), .in_rowB(in_rowB), .in_rowC(in_rowC), .in_rowD(in_rowD),
        .data_outA(data_outA), .data_outB(data_outB), .data_outC(data_outC), .data_outD(data_outD),
        .last_end(last_end), .mat_start(mat_start), .row_idx(row_idx), .busy(busy)
    );

    qr_row_feeder #(.ROW_CYCLES(1), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_rowA(in2A), .in_rowB(in2B), .in_rowC(in2C), .in_rowD(in2D),
        .data_outA(d2A), .data_outB(d2B), .data_outC(d2C), .data_outD(d2D),
        .last_end(last_end2), .mat_start(mat_start2), .row_idx(row_idx2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic row_t make_row(input int s, input int r);
        row_t x;
        if (s == 0) begin
            x.a = W'(r); x.b = W'(-r); x.c = W'(100 + r); x.d = W'(-4096);
        end else begin
            x.a = W'(s*32 + r); x.b = W'(-(s*32 + r));
            x.c = W'(100 + s*10 + r); x.d = W'(4095 - 37*r - s);
        end
        return x;
    endfunction

    // Scoreboard: rows pushed on acceptance, popped at each presented row.
    always @(negedge clk) begin
        if (reset) begin
            k = -1;
            sb.delete();
        end else begin
            if (k < 0 && mat_start) k = 0;
            if (k >= 0) begin
                check("mat_start_once", mat_start, (k == 0));
                if (k % RC == 0) begin
                    check("sb_nonempty", (sb.size() != 0), 1);
                    if (sb.size() != 0) cur = sb.pop_front();
                end
                check("row_idx", row_idx, k / RC);
                check("last_end", last_end, (k / RC == ROWS - 1));
                check("busy_stream", busy, 1);
                check("dataA", data_outA, cur.a);
                check("dataB", data_outB, cur.b);
                check("dataC", data_outC, cur.c);
                check("dataD", data_outD, cur.d);
                k++;
                if (k == ROWS * RC) k = -1;
            end else begin
                check("idle_zero", {data_outA, data_outB, data_outC, data_outD, last_end, mat_start}, 0);
            end
            if (in_valid && in_ready) sb.push_back('{in_rowA, in_rowB, in_rowC, in_rowD});
        end
    end

    always @(negedge clk) begin
        if (reset) sb2.delete();
        else if (in_valid2 && in_ready2) sb2.push_back('{in2A, in2B, in2C, in2D});
        if (log2_en && log2.size() < 40)
            log2.push_back('{'{d2A, d2B, d2C, d2D}, last_end2, mat_start2, busy2});
    end

    task automatic write_rows(input int s, input int n, input int stall_row,
                              output int stalls_total, output int stalls_at);
        row_t x;
        stalls_total = 0;
        stalls_at = 0;
        for (int i = 0; i < n; i++) begin
            x = make_row(s, i);
            in_rowA = x.a; in_rowB = x.b; in_rowC = x.c; in_rowD = x.d;
            in_valid = 1;
            for (int w = 0; !in_ready && w < 200; w++) begin
                stalls_total++;
                if (i == stall_row) stalls_at++;
                @(posedge clk); #1;
            end
            if (!in_ready) check("write_timeout", in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 0;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 400; w++) begin
            @(negedge clk);
            if (!busy && k < 0 && sb.size() == 0) break;
        end
        check("idle_timeout", {busy, (k >= 0), (sb.size() != 0)}, 0);
    endtask

    initial begin
        int st, sa, le, first, tog, f;
        row_t x;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", {data_outA, data_outB, data_outC, data_outD, last_end, mat_start, row_idx, busy}, 0);
        check("rst_in_ready2", in_ready2, 1);
        check("rst_busy2", busy2, 0);
        @(posedge clk); #1;

        // 1: single matrix, latency, last_end window, gap
        write_rows(0, 4, -1, st, sa);
        check("t1_no_stall", st, 0);
        check("t1_in_ready", in_ready, 1);
        @(negedge clk); check("t1_ms_lat0", mat_start, 0);
        @(negedge clk); check("t1_ms_lat1", mat_start, 0);
        @(negedge clk); check("t1_ms_lat2", mat_start, 1);
        le = 0; first = -1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (last_end) begin le++; if (first < 0) first = c; end
        end
        check("t1_le_count", le, 4);
        check("t1_le_first", first, 12);
        for (int g = 0; g < 16; g++) begin
            @(negedge clk);
            check("t1_gap", {busy, data_outA, data_outB, data_outC, data_outD}, {1'b1, 52'd0});
        end
        @(negedge clk); check("t1_busy_after_gap", busy, 0);
        wait_idle();

        // 2: two matrices back to back
        @(posedge clk); #1;
        write_rows(1, 8, -1, st, sa);
        check("t2_no_stall", st, 0);
        check("t2_in_ready_low", in_ready, 0);
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        check("t2_in_ready_rise", in_ready, 1);
        check("t2_rise_at_last", last_end, 1);
        for (int g = 0; g < 16; g++) begin
            @(negedge clk);
            check("t2_gap_busy", {busy, mat_start}, 2'b10);
        end
        @(negedge clk); check("t2_idle_cycle", {busy, mat_start}, 2'b00);
        @(negedge clk); check("t2_second_start", mat_start, 1);
        wait_idle();

        // 3: 12 rows with in_valid held high
        @(posedge clk); #1;
        write_rows(2, 12, 8, st, sa);
        check("t3_row9_stalled", (sa > 0), 1);
        wait_idle();

        // 4: reset during row 2 of a stream, with a partial fill pending
        @(posedge clk); #1;
        write_rows(3, 6, -1, st, sa);
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (busy && row_idx == 2) break;
        end
        check("t4_row2_seen", row_idx, 2);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("t4_out_zero", {data_outA, data_outB, data_outC, data_outD, last_end, mat_start, row_idx}, 0);
        check("t4_busy", busy, 0);
        check("t4_in_ready", in_ready, 1);
        @(posedge clk); #1;
        write_rows(4, 4, -1, st, sa);
        wait_idle();

        // 5: random in_valid while stalled
        @(posedge clk); #1;
        write_rows(5, 8, -1, st, sa);
        tog = 0;
        for (int w = 0; w < 200; w++) begin
            @(posedge clk); #1;
            if (in_ready) break;
            in_valid = 1'($urandom_range(0, 1));
            in_rowA = W'($urandom); in_rowB = W'($urandom);
            in_rowC = W'($urandom); in_rowD = W'($urandom);
            tog++;
        end
        in_valid = 0;
        check("t5_stalled", (tog > 0), 1);
        wait_idle();

        // 6: no gap, one cycle per row, two queued matrices
        log2_en = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            x = make_row(6, i);
            in2A = x.a; in2B = x.b; in2C = x.c; in2D = x.d;
            in_valid2 = 1;
            check("t6_in_ready2", in_ready2, 1);
            @(posedge clk); #1;
        end
        in_valid2 = 0;
        repeat (20) @(negedge clk);
        log2_en = 0;
        f = -1;
        foreach (log2[i]) if (log2[i].ms && f < 0) f = i;
        check("t6_start_found", (f >= 0 && f + 8 < log2.size()), 1);
        if (f >= 0 && f + 8 < log2.size()) begin
            for (int c = 0; c < 8; c++) begin
                check("t6_sb2_nonempty", (sb2.size() != 0), 1);
                if (sb2.size() != 0) x = sb2.pop_front();
                check("t6_data", {log2[f+c].d.a, log2[f+c].d.b, log2[f+c].d.c, log2[f+c].d.d},
                      {x.a, x.b, x.c, x.d});
                check("t6_last_end", log2[f+c].le, (c == 3 || c == 7));
                check("t6_mat_start", log2[f+c].ms, (c == 0 || c == 4));
                check("t6_busy", log2[f+c].bz, 1);
            end
            check("t6_after", {log2[f+8].bz, log2[f+8].d.a}, 0);
        end

        check("sb_leftover", sb.size(), 0);
        check("sb2_leftover", sb2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
